// File: rtl/pipeline_regs_pkg.sv
// pipeline_regs_pkg
//   Shared constants and types for the pipeline_regs slice.
//   - N_DEFAULT / STAGES_DEFAULT : default data width and stage count.
//   - stage_t                    : one stage record {valid, data} at the
//                                  default width. The top declares its own
//                                  record with the same layout for any N.
//   - count_width()              : width needed to hold 0..STAGES.
package pipeline_regs_pkg;

  localparam int N_DEFAULT      = 64;
  localparam int STAGES_DEFAULT = 4;

  // valid sits in the MSB so the record packs as {valid, data}.
  typedef struct packed {
    logic                 valid;
    logic [N_DEFAULT-1:0] data;
  } stage_t;

  // Occupancy ranges over 0..stages inclusive, so it needs stages+1 codes.
  function automatic int count_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipeline_regs_if.sv
// pipeline_regs_if
//   Bundles the data-path signals of pipeline_regs. clk and reset stay
//   plain ports on the design.
//   Parameters: N (data width), STAGES (stage count); CW is derived.
//   Signals:
//     en      : advance enable, 0 = every stage holds
//     flush   : synchronous clear of every stage (not a reset)
//     d       : data into stage 0
//     d_valid : d is a valid entry
//     q       : data of the last stage
//     q_valid : valid flag of the last stage
//     count   : number of valid entries held across all stages
//   Handshake: d_valid qualifies d on any edge where en=1 and flush=0, and
//   that entry is always taken. There is no ready or backpressure signal;
//   en is the only flow control. q_valid qualifies q, and q is all-zero
//   whenever q_valid is 0.
//   Modports: master = producer/consumer side, slave = pipeline_regs.
interface pipeline_regs_if
  import pipeline_regs_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int STAGES = STAGES_DEFAULT
) ();

  localparam int CW = count_width(STAGES);

  logic          en;
  logic          flush;
  logic [N-1:0]  d;
  logic          d_valid;
  logic [N-1:0]  q;
  logic          q_valid;
  logic [CW-1:0] count;

  modport master (
    output en,
    output flush,
    output d,
    output d_valid,
    input  q,
    input  q_valid,
    input  count
  );

  modport slave (
    input  en,
    input  flush,
    input  d,
    input  d_valid,
    output q,
    output q_valid,
    output count
  );

endinterface

// File: rtl/pipeline_regs_flopenr.sv
// flopenr
//   W-bit register with synchronous active-high reset and a load enable.
//   Ports: clk, reset (sync, active-high), en (load), d (next), q (state).
module flopenr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_regs.sv
// pipeline_regs
//   STAGES-deep register pipeline of {valid, data} records with stall,
//   flush and a registered occupancy counter.
//   Ports:
//     clk   : single clock, rising edge
//     reset : synchronous, active-high; clears every stage and count
//     bus   : pipeline_regs_if.slave (en, flush, d, d_valid in;
//             q, q_valid, count out)
//   Priority per edge: reset > flush > en > hold.
//   Latency: an entry taken at edge t is on q after edge t+STAGES-1.
module pipeline_regs
  import pipeline_regs_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int STAGES = STAGES_DEFAULT,
  // Derived from STAGES; not meant to be overridden.
  localparam int CW    = count_width(STAGES)
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_regs_if.slave bus
);

  // Same layout as stage_t, sized for this instance's N.
  typedef struct packed {
    logic         valid;
    logic [N-1:0] data;
  } rec_t;

  localparam int W = $bits(rec_t);

  rec_t stage_q [STAGES];
  rec_t head;
  logic stage_en;

  // Invalid entries carry zero data so q is zero whenever q_valid is 0.
  always_comb begin
    head       = '0;
    head.valid = bus.d_valid;
    head.data  = bus.d_valid ? bus.d : '0;
  end

  // flush is folded into the enable and data of every stage so that the
  // stage reset stays dedicated to the real reset.
  assign stage_en = bus.en | bus.flush;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rec_t din;

    if (k == 0) begin : g_head
      assign din = bus.flush ? rec_t'('0) : head;
    end else begin : g_body
      assign din = bus.flush ? rec_t'('0) : stage_q[k-1];
    end

    flopenr #(
      .W (W)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (stage_en),
      .d     (din),
      .q     (stage_q[k])
    );
  end

  assign bus.q       = stage_q[STAGES-1].data;
  assign bus.q_valid = stage_q[STAGES-1].valid;

  // Occupancy tracks the valid bits incrementally: on an advance one entry
  // (possibly a bubble) enters and the last stage leaves. When full with
  // d_valid=1 the +1 may wrap in CW bits, but the -1 brings it back, so
  // the modular sum still equals STAGES.
  logic [CW-1:0] count_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (bus.flush) begin
      count_r <= '0;
    end else if (bus.en) begin
      count_r <= count_r + CW'(bus.d_valid) - CW'(stage_q[STAGES-1].valid);
    end
  end

  assign bus.count = count_r;

endmodule

// File: doc/pipeline_regs.md
PIPELINE_REGS -- requirements
Module: pipeline_regs

Interface
REQ-001 The block SHALL have parameter N, default 64, data width in bits (N >= 1).
REQ-002 The block SHALL have parameter STAGES, default 4, number of register stages (STAGES >= 1).
REQ-003 The block SHALL have parameter CW, default $clog2(STAGES+1), occupancy count width (derived, not overridden).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  reset, synchronous, active-high.
REQ-006 Port en  input  1  advance enable; 0 = stall, all stages hold.
REQ-007 Port flush  input  1  synchronous clear of all stages, non-reset.
REQ-008 Port d  input  N  data into stage 0.
REQ-009 Port d_valid  input  1  d is a valid entry.
REQ-010 Port q  output  N  data of last stage.
REQ-011 Port q_valid  output  1  valid flag of last stage.
REQ-012 Port count  output  CW  number of valid entries currently held across all stages.

Function
REQ-013 Each stage SHALL hold an N-bit data word plus a valid bit; q/q_valid SHALL be the last stage, registered, with no combinational path from any input.
REQ-014 Priority per rising edge SHALL be: reset > flush > en > hold.
REQ-015 With en=1, stage 0 SHALL load {d_valid, d_valid ? d : 0} and stage k SHALL load stage k-1, for k = 1..STAGES-1.
REQ-016 An entry presented at edge t with en held 1 SHALL appear on q/q_valid after edge t+STAGES-1, i.e. latency STAGES cycles.
REQ-017 Invalid entries SHALL carry all-zero data: q SHALL equal 0 whenever q_valid=0.
REQ-018 With en=0 and flush=0, every stage, q, q_valid and count SHALL hold their values; d/d_valid SHALL be ignored.
REQ-019 flush=1 SHALL clear every data word to 0 and every valid bit to 0 at that edge, regardless of en; the entry on d SHALL be dropped.
REQ-020 count SHALL be registered and SHALL equal the number of set stage valid bits after each edge; it SHALL be updated as count + d_valid - q_valid(old) when en=1, and held when en=0.
REQ-021 count SHALL never exceed STAGES; STAGES valid entries in flight with en=1 and d_valid=1 SHALL keep count at STAGES (one enters, one leaves).
REQ-022 STAGES=1 SHALL degenerate to a single enabled register with valid flag and latency 1.

Reset
REQ-023 On reset=1 at a rising edge, all stage data SHALL be 0, all valid bits 0, q=0, q_valid=0, count=0, irrespective of en, flush, d, d_valid.
REQ-024 reset SHALL act only at clock edges; asserting it mid-stream SHALL discard all in-flight entries at the next edge.
REQ-025 After reset deasserts, the first entry accepted SHALL appear on q exactly STAGES cycles later.

Structure
REQ-026 Package pipeline_regs_pkg SHALL hold default constants N_DEFAULT=64 and STAGES_DEFAULT=4 and the typedef of the stage record {valid, data}.
REQ-027 Each stage SHALL be an instance of sub-module flopenr #(N+1) (synchronous active-high reset, enable, d, q), generated STAGES times; flush SHALL be folded into its data/enable inputs, not into its reset.
REQ-028 count SHALL be a separate registered counter in pipeline_regs, not a popcount of the valid bits.

Verification
REQ-029 Reset: reset=1 for 5 cycles with d=64'hFFFF_FFFF_FFFF_FFFF, d_valid=1, en=1 -> q=0, q_valid=0, count=0 every cycle.
REQ-030 Streaming: en=1, d_valid=1, d=1,2,...,10 on consecutive edges, STAGES=4 -> q=1..10 on consecutive cycles starting 4 cycles after first input, q_valid=1, count rises 1,2,3,4 and stays 4.
REQ-031 Bubbles: d_valid pattern 1,0,1,0 with d=5,6,7,8 -> q sequence 5,0,7,0 with q_valid 1,0,1,0; count never exceeds 2.
REQ-032 Stall: load 1,2,3,4, then en=0 for 3 cycles with d=9 -> q, q_valid, count frozen; en=1 resumes with q=1 next and no 9 ever emitted.
REQ-033 Flush: with count=4, assert flush=1 together with en=1, d=9, d_valid=1 -> next cycle q=0, q_valid=0, count=0; 9 never appears on q.
REQ-034 Parametrisation: repeat REQ-030 with N=32, STAGES=1 and with N=8, STAGES=7 -> latency 1 and 7 respectively, upper data bits unaffected.
